gray_updown_counter: RTL and testbench

- Parametrised N-bit Gray-code counter, successor to the fixed up-only Gray counter.
- Adds up/down direction, count enable, synchronous load of a Gray value, wrap or saturate mode, and boundary flags.
- Gray and binary outputs are registered and always mutually consistent, with no one-cycle lag between them.
- Used for clock-domain-crossing pointers such as async FIFO read/write pointers, and for position encoders.

---
 rtl/gray_updown_counter.sv | 127 ++++++++++++
 tb/tb_gray_updown_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with load, wrap/saturate and boundary flags.
// Optional Gray-step checker enabled by defining GRAY_CNT_CHK_EN.
module gray_updown_counter #(
  parameter int unsigned N         = 4,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_gray,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         at_max,
  output logic         at_min,
  output logic         wrap,
  output logic         err
);

  localparam logic [N-1:0] BIN_MAX  = '1;
  localparam logic [N-1:0] ZERO     = '0;
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] RST_BIN  = N'(RESET_VAL);
  localparam logic [N-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [N-1:0] r_bin;
  logic [N-1:0] r_gray;
  logic         r_wrap;
  logic [N-1:0] w_load_bin;
  logic [N-1:0] w_nxt_bin;
  logic [N-1:0] w_nxt_gray;
  logic         w_nxt_wrap;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = int'(N) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_load_bin = gray2bin(load_gray);

  // Next binary value and wrap pulse; load outranks enable.
  always_comb begin
    w_nxt_bin  = r_bin;
    w_nxt_wrap = 1'b0;
    if (load) begin
      w_nxt_bin = w_load_bin;
    end else if (en) begin
      if (up) begin
        if (r_bin == BIN_MAX) begin
          if (!SATURATE) begin
            w_nxt_bin  = ZERO;
            w_nxt_wrap = 1'b1;
          end
        end else begin
          w_nxt_bin = r_bin + ONE;
        end
      end else begin
        if (r_bin == ZERO) begin
          if (!SATURATE) begin
            w_nxt_bin  = BIN_MAX;
            w_nxt_wrap = 1'b1;
          end
        end else begin
          w_nxt_bin = r_bin - ONE;
        end
      end
    end
  end

  // Gray is derived from the same next value so both registers stay in lockstep.
  assign w_nxt_gray = load ? load_gray : (w_nxt_bin ^ (w_nxt_bin >> 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_nxt_bin;
      r_gray <= w_nxt_gray;
      r_wrap <= w_nxt_wrap;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  assign at_max   = (r_bin == BIN_MAX);
  assign at_min   = (r_bin == ZERO);

`ifdef GRAY_CNT_CHK_EN
  logic [N-1:0] r_prev_gray;
  logic         r_chk_arm;
  logic         r_err;
  logic [N-1:0] w_step_diff;
  logic         w_multi_bit;

  // r_chk_arm marks that the last transition into r_gray was a count/hold, not load/reset.
  assign w_step_diff = r_gray ^ r_prev_gray;
  assign w_multi_bit = ((w_step_diff & (w_step_diff - ONE)) != ZERO);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_prev_gray <= RST_GRAY;
      r_chk_arm   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_prev_gray <= r_gray;
      r_chk_arm   <= !load;
      if (r_chk_arm && w_multi_bit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: a wrapping instance (RESET_VAL=0) and a saturating
// instance (RESET_VAL=5) share stimulus and are checked against an integer model.
module tb_gray_updown_counter;

  localparam int unsigned N = 4;
  localparam int MAXV = 15;

  logic         clk = 1'b0;
  logic         rstn, en, up, load;
  logic [N-1:0] load_gray;
  logic [N-1:0] gray_o [2];
  logic [N-1:0] bin_o  [2];
  logic         max_o  [2];
  logic         min_o  [2];
  logic         wrap_o [2];
  logic         err_o  [2];

  int total = 0;
  int bad   = 0;

  int  m_bin  [2];
  bit  m_wrap [2];
  int  rst_v  [2] = '{0, 5};
  bit  sat_v  [2] = '{1'b0, 1'b1};
  logic [N-1:0] g_before [2];

  always #5 clk = ~clk;

  gray_updown_counter #(.N(N), .RESET_VAL(0), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .gray_out(gray_o[0]), .bin_out(bin_o[0]), .at_max(max_o[0]), .at_min(min_o[0]),
    .wrap(wrap_o[0]), .err(err_o[0])
  );

  gray_updown_counter #(.N(N), .RESET_VAL(5), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .gray_out(gray_o[1]), .bin_out(bin_o[1]), .at_max(max_o[1]), .at_min(min_o[1]),
    .wrap(wrap_o[1]), .err(err_o[1])
  );

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Gray decoding by search: the binary value whose Gray encoding matches.
  function automatic int decode_gray(input int g);
    for (int v = 0; v <= MAXV; v++) if ((v ^ (v >> 1)) == g) return v;
    return -1;
  endfunction

  function automatic int ones(input int x);
    int c = 0;
    for (int b = 0; b < 32; b++) c += (x >> b) & 1;
    return c;
  endfunction

  task automatic model_step(input int k);
    if (!rstn) begin
      m_bin[k] = rst_v[k]; m_wrap[k] = 1'b0;
    end else if (load) begin
      m_bin[k] = decode_gray(int'(load_gray)); m_wrap[k] = 1'b0;
    end else if (en) begin
      int nxt = up ? m_bin[k] + 1 : m_bin[k] - 1;
      m_wrap[k] = 1'b0;
      if (nxt < 0 || nxt > MAXV) begin
        if (!sat_v[k]) begin
          m_bin[k] = (nxt + 16) % 16; m_wrap[k] = 1'b1;
        end
      end else begin
        m_bin[k] = nxt;
      end
    end else begin
      m_wrap[k] = 1'b0;
    end
  endtask

  task automatic check_all(input bit was_count);
    for (int k = 0; k < 2; k++) begin
      int exp_g = m_bin[k] ^ (m_bin[k] >> 1);
      chk("bin", k, int'(bin_o[k]), m_bin[k]);
      chk("gray", k, int'(gray_o[k]), exp_g);
      chk("at_max", k, int'(max_o[k]), int'(m_bin[k] == MAXV));
      chk("at_min", k, int'(min_o[k]), int'(m_bin[k] == 0));
      chk("wrap", k, int'(wrap_o[k]), int'(m_wrap[k]));
      chk("err", k, int'(err_o[k]), 0);
      if (was_count)
        chk("step_bits", k, ones(int'(gray_o[k] ^ g_before[k])),
            int'(exp_g != int'(g_before[k])));
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic u,
                       input logic l, input logic [N-1:0] lg);
    bit was_count;
    @(negedge clk);
    rstn = r; en = e; up = u; load = l; load_gray = lg;
    for (int k = 0; k < 2; k++) g_before[k] = gray_o[k];
    was_count = r && !l;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    check_all(was_count);
  endtask

  int seq_tbl [17] = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4,
                       'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8, 'h0};

  initial begin
    rstn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = '0;
    m_bin = '{0, 5}; m_wrap = '{1'b0, 1'b0};

    // Reset values of both instances.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("rst_gray5", 1, int'(gray_o[1]), 'h7);
    chk("rst_bin5", 1, int'(bin_o[1]), 5);
    chk("rst_gray0", 0, int'(gray_o[0]), 0);

    // Full up-count lap on the wrapping instance.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      chk("seq_gray", 0, int'(gray_o[0]), seq_tbl[i]);
      chk("seq_wrap", 0, int'(wrap_o[0]), int'(i == 16));
    end

    // Load C with en high, then count down through zero.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hC);
    chk("load_bin", 0, int'(bin_o[0]), 8);
    chk("load_gray", 0, int'(gray_o[0]), 'hC);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      chk("down_bin", 0, int'(bin_o[0]), (i < 8) ? 7 - i : 15);
      chk("down_wrap", 0, int'(wrap_o[0]), int'(i == 8));
    end

    // Saturation at max: load F (Gray 8), push up three times, then step down.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      chk("sat_hold", 1, int'(bin_o[1]), 15);
      chk("sat_max", 1, int'(max_o[1]), 1);
      chk("sat_wrap", 1, int'(wrap_o[1]), 0);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("sat_down", 1, int'(bin_o[1]), 14);

    // Saturation at min, then direction change with no dead cycle.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("sat_min", 1, int'(bin_o[1]), 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("dir_chg", 1, int'(bin_o[1]), 1);

    // Reset coincident with load and en mid-count.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    chk("rst_over_ld", 0, int'(bin_o[0]), 0);
    chk("rst_over_ld", 1, int'(bin_o[1]), 5);

    // Hold when idle.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h3);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 49) != 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) == 0),
            4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
